// File: rtl/wb_core_bus_arbiter_pkg.sv
// wb_core_bus_arbiter_pkg: shared FSM state encoding and grant-id constants
package wb_core_bus_arbiter_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;
    localparam logic IBUS = 1'b0;
    localparam logic DBUS = 1'b1;
endpackage

// File: rtl/wb_core_bus_arbiter_if.sv
// wb_core_bus_arbiter_if: IBUS, DBUS and shared slave Wishbone signals
interface wb_core_bus_arbiter_if;
    logic [31:0] wb_ibus_adr_i;
    logic [31:0] wb_ibus_dat_o;
    logic        wb_ibus_stb_i;
    logic        wb_ibus_ack_o;
    logic [31:0] wb_dbus_adr_i;
    logic [31:0] wb_dbus_dat_i;
    logic [31:0] wb_dbus_dat_o;
    logic        wb_dbus_we_i;
    logic [3:0]  wb_dbus_sel_i;
    logic        wb_dbus_stb_i;
    logic        wb_dbus_cyc_i;
    logic        wb_dbus_ack_o;
    logic [31:0] wb_s_adr_o;
    logic [31:0] wb_s_dat_o;
    logic [3:0]  wb_s_sel_o;
    logic        wb_s_we_o;
    logic        wb_s_stb_o;
    logic        wb_s_cyc_o;
    logic [31:0] wb_s_dat_i;
    logic        wb_s_ack_i;
    modport slave (
        input  wb_ibus_adr_i, wb_ibus_stb_i, wb_dbus_adr_i, wb_dbus_dat_i, wb_dbus_we_i,
               wb_dbus_sel_i, wb_dbus_stb_i, wb_dbus_cyc_i, wb_s_dat_i, wb_s_ack_i,
        output wb_ibus_dat_o, wb_ibus_ack_o, wb_dbus_dat_o, wb_dbus_ack_o,
               wb_s_adr_o, wb_s_dat_o, wb_s_sel_o, wb_s_we_o, wb_s_stb_o, wb_s_cyc_o
    );
    modport master (
        output wb_ibus_adr_i, wb_ibus_stb_i, wb_dbus_adr_i, wb_dbus_dat_i, wb_dbus_we_i,
               wb_dbus_sel_i, wb_dbus_stb_i, wb_dbus_cyc_i, wb_s_dat_i, wb_s_ack_i,
        input  wb_ibus_dat_o, wb_ibus_ack_o, wb_dbus_dat_o, wb_dbus_ack_o,
               wb_s_adr_o, wb_s_dat_o, wb_s_sel_o, wb_s_we_o, wb_s_stb_o, wb_s_cyc_o
    );
endinterface

// File: rtl/wb_core_bus_arbiter_timeout_ctr.sv
// wb_timeout_ctr: watchdog counting granted cycles without ack; tied off when TIMEOUT_CYCLES=0
module wb_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic ack,
    output logic expire
);
    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused;
            assign unused = ^{clk, rst, clr, en, ack};
            assign expire = 1'b0;
        end else begin : g_on
            localparam int W = $clog2(TIMEOUT_CYCLES + 1);
            logic [W-1:0] cnt;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) cnt <= '0;
                else if (clr) cnt <= '0;
                else if (en && !ack) cnt <= cnt + 1'b1;
            end
            assign expire = en && !ack && cnt == W'(TIMEOUT_CYCLES - 1);
        end
    endgenerate
endmodule

// File: rtl/wb_core_bus_arbiter.sv
// wb_core_bus_arbiter: shares one Wishbone classic slave port between IBUS and DBUS,
// with registered grant, round-robin or DBUS-priority arbitration and a hang watchdog.
module wb_core_bus_arbiter
    import wb_core_bus_arbiter_pkg::*;
#(
    parameter bit RR_EN          = 1'b1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    wb_core_bus_arbiter_if.slave  bus,
    input  logic                  timeout_clr_i,
    output logic                  timeout_o,
    output logic [31:0]           timeout_adr_o
);
    state_t state, state_nx;
    logic last_grant, ireq, dreq, gi, gd, req, ack, expire;
    logic [31:0] adr;
    assign ireq = bus.wb_ibus_stb_i;
    assign dreq = bus.wb_dbus_stb_i & bus.wb_dbus_cyc_i;
    assign gi   = state == GNT_I;
    assign gd   = state == GNT_D;
    assign req  = (gi & ireq) | (gd & dreq);
    assign ack  = req & bus.wb_s_ack_i;
    assign adr  = gi ? bus.wb_ibus_adr_i : gd ? bus.wb_dbus_adr_i : '0;

    wb_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk(wb_clk_i), .rst(wb_rst_i), .clr(state == IDLE), .en(req), .ack(ack), .expire(expire)
    );

    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = (dreq && (!ireq || !RR_EN || last_grant == IBUS)) ? GNT_D : ireq ? GNT_I : IDLE;
        else if (!req || ack || expire)
            state_nx = IDLE;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            last_grant <= IBUS;
        end else begin
            state <= state_nx;
            if (ack || expire) last_grant <= gd ? DBUS : IBUS;
        end
    end

    // a fresh expiry outranks a simultaneous clear request
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            timeout_o     <= 1'b0;
            timeout_adr_o <= '0;
        end else if (expire) begin
            timeout_o     <= 1'b1;
            timeout_adr_o <= adr;
        end else if (timeout_clr_i) begin
            timeout_o <= 1'b0;
        end
    end

    assign bus.wb_s_adr_o    = adr;
    assign bus.wb_s_dat_o    = gd ? bus.wb_dbus_dat_i : '0;
    assign bus.wb_s_sel_o    = gi ? 4'hF : gd ? bus.wb_dbus_sel_i : 4'h0;
    assign bus.wb_s_we_o     = gd & bus.wb_dbus_we_i;
    assign bus.wb_s_stb_o    = req & ~expire;
    assign bus.wb_s_cyc_o    = req & ~expire;
    assign bus.wb_ibus_ack_o = gi & (ack | expire);
    assign bus.wb_dbus_ack_o = gd & (ack | expire);
    assign bus.wb_ibus_dat_o = expire ? '0 : bus.wb_s_dat_i;
    assign bus.wb_dbus_dat_o = expire ? '0 : bus.wb_s_dat_i;
endmodule

// File: tb/tb_wb_core_bus_arbiter.sv
// tb_wb_core_bus_arbiter: directed and randomized checks of the IBUS/DBUS arbiter
// against a transaction-level model (winner rule, completion cycle, timeout outcome).
module tb_wb_core_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_a = 1'b0, clr_b = 1'b0;
    logic to_a, to_b;
    logic [31:0] toa_a, toa_b;
    int n_total = 0, n_pass = 0, n_fail = 0;

    always #5 clk = ~clk;

    wb_core_bus_arbiter_if bi ();
    wb_core_bus_arbiter_if bf ();

    wb_core_bus_arbiter #(.RR_EN(1'b1), .TIMEOUT_CYCLES(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .bus(bi),
        .timeout_clr_i(clr_a), .timeout_o(to_a), .timeout_adr_o(toa_a)
    );

    wb_core_bus_arbiter #(.RR_EN(1'b0), .TIMEOUT_CYCLES(0)) dut_fp (
        .wb_clk_i(clk), .wb_rst_i(rst), .bus(bf),
        .timeout_clr_i(clr_b), .timeout_o(to_b), .timeout_adr_o(toa_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic mlast, w, ir, dr, dwe, timed, busy;
        logic [31:0] ia, da, dd, rd;
        logic [3:0] dsel;
        int lat, fin;
        bi.wb_ibus_adr_i = '0; bi.wb_ibus_stb_i = 0; bi.wb_dbus_adr_i = '0; bi.wb_dbus_dat_i = '0;
        bi.wb_dbus_we_i = 0; bi.wb_dbus_sel_i = '0; bi.wb_dbus_stb_i = 0; bi.wb_dbus_cyc_i = 0;
        bi.wb_s_dat_i = '0; bi.wb_s_ack_i = 0;
        bf.wb_ibus_adr_i = '0; bf.wb_ibus_stb_i = 0; bf.wb_dbus_adr_i = '0; bf.wb_dbus_dat_i = '0;
        bf.wb_dbus_we_i = 0; bf.wb_dbus_sel_i = '0; bf.wb_dbus_stb_i = 0; bf.wb_dbus_cyc_i = 0;
        bf.wb_s_dat_i = '0; bf.wb_s_ack_i = 0;
        step(); step(); settle();
        chk("rst_stb", bi.wb_s_stb_o, 0);
        chk("rst_cyc", bi.wb_s_cyc_o, 0);
        chk("rst_iack", bi.wb_ibus_ack_o, 0);
        chk("rst_dack", bi.wb_dbus_ack_o, 0);
        chk("rst_to", to_a, 0);
        chk("rst_toadr", toa_a, 0);
        rst = 0;
        // single IBUS read, slave acks two cycles after stb
        step(); bi.wb_ibus_adr_i = 32'h100; bi.wb_ibus_stb_i = 1; settle();
        chk("ib_idle_stb", bi.wb_s_stb_o, 0);
        step(); settle();
        chk("ib_stb", bi.wb_s_stb_o, 1);
        chk("ib_cyc", bi.wb_s_cyc_o, 1);
        chk("ib_we", bi.wb_s_we_o, 0);
        chk("ib_sel", bi.wb_s_sel_o, 4'hF);
        chk("ib_adr", bi.wb_s_adr_o, 32'h100);
        chk("ib_noack1", bi.wb_ibus_ack_o, 0);
        step(); settle();
        chk("ib_noack2", bi.wb_ibus_ack_o, 0);
        step(); bi.wb_s_ack_i = 1; bi.wb_s_dat_i = 32'hDEADBEEF; settle();
        chk("ib_ack", bi.wb_ibus_ack_o, 1);
        chk("ib_dat", bi.wb_ibus_dat_o, 32'hDEADBEEF);
        chk("ib_dack0", bi.wb_dbus_ack_o, 0);
        // DBUS write during the mandatory idle cycle
        step(); bi.wb_ibus_stb_i = 0; bi.wb_s_ack_i = 0;
        bi.wb_dbus_adr_i = 32'h2000_0004; bi.wb_dbus_dat_i = 32'h1234_5678; bi.wb_dbus_sel_i = 4'b0011;
        bi.wb_dbus_we_i = 1; bi.wb_dbus_stb_i = 1; bi.wb_dbus_cyc_i = 1; settle();
        chk("gap_stb", bi.wb_s_stb_o, 0);
        step(); bi.wb_s_ack_i = 1; settle();
        chk("dw_adr", bi.wb_s_adr_o, 32'h2000_0004);
        chk("dw_dat", bi.wb_s_dat_o, 32'h1234_5678);
        chk("dw_sel", bi.wb_s_sel_o, 4'b0011);
        chk("dw_we", bi.wb_s_we_o, 1);
        chk("dw_dack", bi.wb_dbus_ack_o, 1);
        chk("dw_iack0", bi.wb_ibus_ack_o, 0);
        step(); bi.wb_dbus_stb_i = 0; bi.wb_dbus_cyc_i = 0; bi.wb_dbus_we_i = 0; bi.wb_s_ack_i = 0;
        // abort, then spurious ack in IDLE
        bi.wb_ibus_adr_i = 32'h300; bi.wb_ibus_stb_i = 1;
        step(); settle();
        chk("ab_stb1", bi.wb_s_stb_o, 1);
        step(); bi.wb_ibus_stb_i = 0; settle();
        chk("ab_stb2", bi.wb_s_stb_o, 0);
        chk("ab_iack", bi.wb_ibus_ack_o, 0);
        step(); bi.wb_s_ack_i = 1; settle();
        chk("sp_iack", bi.wb_ibus_ack_o, 0);
        chk("sp_dack", bi.wb_dbus_ack_o, 0);
        chk("sp_stb", bi.wb_s_stb_o, 0);
        bi.wb_s_ack_i = 0;
        // watchdog timeout on a DBUS read
        bi.wb_dbus_adr_i = 32'h40; bi.wb_dbus_stb_i = 1; bi.wb_dbus_cyc_i = 1; bi.wb_s_dat_i = 32'hAAAA5555;
        for (int k = 1; k <= 3; k++) begin
            step(); settle();
            chk("to_wait_ack", bi.wb_dbus_ack_o, 0);
            chk("to_wait_stb", bi.wb_s_stb_o, 1);
        end
        step(); settle();
        chk("to_fack", bi.wb_dbus_ack_o, 1);
        chk("to_fdat", bi.wb_dbus_dat_o, 0);
        chk("to_stb", bi.wb_s_stb_o, 0);
        chk("to_flag_pre", to_a, 0);
        step(); bi.wb_dbus_stb_i = 0; bi.wb_dbus_cyc_i = 0; settle();
        chk("to_flag", to_a, 1);
        chk("to_adr", toa_a, 32'h40);
        clr_a = 1; step(); clr_a = 0; settle();
        chk("to_clr", to_a, 0);
        // real ack coincides with expiry cycle
        bi.wb_dbus_adr_i = 32'h44; bi.wb_dbus_stb_i = 1; bi.wb_dbus_cyc_i = 1;
        step(); step(); step();
        step(); bi.wb_s_ack_i = 1; bi.wb_s_dat_i = 32'hCAFE0001; settle();
        chk("ae_dack", bi.wb_dbus_ack_o, 1);
        chk("ae_dat", bi.wb_dbus_dat_o, 32'hCAFE0001);
        step(); bi.wb_dbus_stb_i = 0; bi.wb_dbus_cyc_i = 0; bi.wb_s_ack_i = 0; settle();
        chk("ae_noflag", to_a, 0);
        // expiry beats a simultaneous clear
        bi.wb_dbus_adr_i = 32'h48; bi.wb_dbus_stb_i = 1; bi.wb_dbus_cyc_i = 1;
        step(); step(); step();
        step(); clr_a = 1; settle();
        chk("sw_fack", bi.wb_dbus_ack_o, 1);
        step(); clr_a = 0; bi.wb_dbus_stb_i = 0; bi.wb_dbus_cyc_i = 0; settle();
        chk("sw_flag", to_a, 1);
        chk("sw_adr", toa_a, 32'h48);
        clr_a = 1; step(); clr_a = 0; settle();
        // async reset mid GNT_D with slave stalled
        bi.wb_dbus_adr_i = 32'h50; bi.wb_dbus_stb_i = 1; bi.wb_dbus_cyc_i = 1;
        step(); settle();
        chk("mr_stb_pre", bi.wb_s_stb_o, 1);
        #2; rst = 1; bi.wb_s_ack_i = 1; #1;
        chk("mr_stb", bi.wb_s_stb_o, 0);
        chk("mr_cyc", bi.wb_s_cyc_o, 0);
        chk("mr_dack", bi.wb_dbus_ack_o, 0);
        chk("mr_iack", bi.wb_ibus_ack_o, 0);
        chk("mr_to", to_a, 0);
        step(); rst = 0; bi.wb_s_ack_i = 0; bi.wb_ibus_adr_i = 32'h60; bi.wb_ibus_stb_i = 1; settle();
        chk("mr_idle", bi.wb_s_stb_o, 0);
        // round robin with both masters requesting and an immediate slave ack
        step(); bi.wb_s_ack_i = bi.wb_s_stb_o; settle();
        chk("rr_adr0", bi.wb_s_adr_o, 32'h50);
        chk("rr_dack0", bi.wb_dbus_ack_o, 1);
        chk("rr_iack0", bi.wb_ibus_ack_o, 0);
        mlast = 1;
        for (int k = 1; k <= 7; k++) begin
            step(); bi.wb_s_ack_i = bi.wb_s_stb_o; settle();
            busy = (k % 2) == 0;
            if (busy) mlast = ~mlast;
            chk("rr_iack", bi.wb_ibus_ack_o, busy && !mlast);
            chk("rr_dack", bi.wb_dbus_ack_o, busy && mlast);
        end
        step(); bi.wb_ibus_stb_i = 0; bi.wb_dbus_stb_i = 0; bi.wb_dbus_cyc_i = 0; bi.wb_s_ack_i = 0;
        // fixed DBUS priority instance
        bf.wb_ibus_stb_i = 1; bf.wb_dbus_stb_i = 1; bf.wb_dbus_cyc_i = 1; settle();
        for (int k = 1; k <= 6; k++) begin
            step(); bf.wb_s_ack_i = bf.wb_s_stb_o; settle();
            chk("fp_dack", bf.wb_dbus_ack_o, (k % 2) == 1);
            chk("fp_iack", bf.wb_ibus_ack_o, 0);
        end
        bf.wb_ibus_stb_i = 0; bf.wb_s_ack_i = 0;
        for (int k = 0; k < 300; k++) step();
        settle();
        chk("fp_nowd_stb", bf.wb_s_stb_o, 1);
        chk("fp_nowd_ack", bf.wb_dbus_ack_o, 0);
        chk("fp_nowd_to", to_b, 0);
        bf.wb_dbus_stb_i = 0; bf.wb_dbus_cyc_i = 0;
        // randomized transactions vs model
        rst = 1; step(); rst = 0; mlast = 0;
        for (int it = 0; it < 24; it++) begin
            ir = 1'($urandom_range(0, 1)); dr = 1'($urandom_range(0, 1));
            if (!ir && !dr) dr = 1;
            ia = $urandom; da = $urandom; dd = $urandom; rd = $urandom;
            dwe = 1'($urandom_range(0, 1)); dsel = 4'($urandom_range(0, 15)); lat = $urandom_range(0, 5);
            bi.wb_ibus_adr_i = ia; bi.wb_ibus_stb_i = ir; bi.wb_dbus_adr_i = da; bi.wb_dbus_dat_i = dd;
            bi.wb_dbus_we_i = dwe; bi.wb_dbus_sel_i = dsel; bi.wb_dbus_stb_i = dr; bi.wb_dbus_cyc_i = dr;
            bi.wb_s_ack_i = 0; bi.wb_s_dat_i = rd; settle();
            chk("rnd_idle", bi.wb_s_stb_o, 0);
            w = dr && (!ir || mlast == 0);
            timed = lat + 1 > 4;
            fin = timed ? 4 : lat + 1;
            for (int k = 1; k <= fin; k++) begin
                step(); bi.wb_s_ack_i = k == lat + 1; settle();
                chk("rnd_adr", bi.wb_s_adr_o, w ? da : ia);
                chk("rnd_sel", bi.wb_s_sel_o, w ? dsel : 4'hF);
                chk("rnd_we", bi.wb_s_we_o, w && dwe);
                chk("rnd_iack", bi.wb_ibus_ack_o, k == fin && !w);
                chk("rnd_dack", bi.wb_dbus_ack_o, k == fin && w);
                chk("rnd_stb", bi.wb_s_stb_o, !(k == fin && timed));
                if (k == fin) chk("rnd_dat", w ? bi.wb_dbus_dat_o : bi.wb_ibus_dat_o, timed ? 32'h0 : rd);
            end
            step(); bi.wb_ibus_stb_i = 0; bi.wb_dbus_stb_i = 0; bi.wb_dbus_cyc_i = 0; bi.wb_s_ack_i = 0; settle();
            chk("rnd_to", to_a, timed);
            if (timed) chk("rnd_toadr", toa_a, w ? da : ia);
            mlast = w;
            clr_a = 1; step(); clr_a = 0; settle();
            chk("rnd_toclr", to_a, 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
